// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Start/done handshake and operand/result bus for serial_subtractor.
// Ports    : start, a, b           - request and operands (master -> slave)
//            busy, done, diff,     - status and result   (slave -> master)
//            borrow_out, ovf
//            ovf exists only when SERIAL_SUB_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial WIDTH-bit subtractor computing a - b, LSB first, one
//            bit per clock, wrapped in a start/done handshake.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - serial_subtractor_if.slave (start, a, b in;
//                   busy, done, diff, borrow_out [, ovf] out)
// Macro    : SERIAL_SUB_OVF_EN - adds the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 most recent difference bits; the bit of the current
  // cycle completes the word, so no bit of the register is ever discarded.
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             bin;

  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             busy_reg;
  logic             done_reg;

  logic ai;
  logic bi;
  logic d;
  logic bnext;
  logic last_bit;

  // Full-subtractor cell on the operand LSBs.
  assign ai       = a_sh[0];
  assign bi       = b_sh[0];
  assign d        = ai ^ bi ^ bin;
  assign bnext    = (~ai & bi) | (~(ai ^ bi) & bin);
  assign res_next = {d, res_sh};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      bin        <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      // busy/done are registered copies of the state being entered.
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          bin    <= bnext;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff_reg   <= res_next;
            borrow_reg <= bnext;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // On the final bit the operand LSBs are the original operand MSBs and d is
  // the result MSB, so overflow needs no separate latch.
  logic ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf_reg <= (ai ^ bi) & (d ^ ai);
    end
  end

  assign bus.ovf = ovf_reg;
`endif

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_reg;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed self-checking bench for serial_subtractor, WIDTH=8.
// Ports    : none (top level)
// Macro    : SERIAL_SUB_OVF_EN - also checks the ovf output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;
  int   total;
  int   seen;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; cnt is the number of ticks taken.
  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  // Count done pulses over n cycles.
  task automatic watch_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb);
    int c;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.start = 1'b0;
    bus.a     = ~av;  // later operand changes must not matter
    bus.b     = ~bv;
    check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    wait_done(20, c);
    check({tag, " latency"}, c, 8);
    check({tag, " diff"}, 32'(bus.diff), 32'(ed));
    check({tag, " borrow"}, 32'(bus.borrow_out), 32'(eb));
    tick();
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, " busy_fall"}, 32'(bus.busy), 32'd0);
    check({tag, " diff_hold"}, 32'(bus.diff), 32'(ed));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset diff", 32'(bus.diff), 32'd0);
    check("reset borrow", 32'(bus.borrow_out), 32'd0);
    rst = 1'b0;
    tick();

    do_op("05-03", 8'h05, 8'h03, 8'h02, 1'b0);
    do_op("FF-01", 8'hFF, 8'h01, 8'hFE, 1'b0);
    do_op("00-00", 8'h00, 8'h00, 8'h00, 1'b0);
    do_op("03-05", 8'h03, 8'h05, 8'hFE, 1'b1);

    // Reset in the middle of a run.
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("midrun diff_hold", 32'(bus.diff), 32'hFE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst diff", 32'(bus.diff), 32'd0);
    check("midrst borrow", 32'(bus.borrow_out), 32'd0);
    watch_done(12, seen);
    check("midrst no_done", seen, 0);
    check("midrst idle", 32'(bus.busy), 32'd0);
    do_op("10-01", 8'h10, 8'h01, 8'h0F, 1'b0);

    // start pulse during RUN is ignored.
    bus.start = 1'b1;
    bus.a     = 8'h20;
    bus.b     = 8'h10;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    check("ignore diff_hold", 32'(bus.diff), 32'h0F);
    tick();
    bus.start = 1'b0;
    wait_done(20, cyc);
    check("ignore latency", cyc, 6);
    check("ignore diff", 32'(bus.diff), 32'h10);
    check("ignore borrow", 32'(bus.borrow_out), 32'd0);
    watch_done(12, seen);
    check("ignore no_second_done", seen, 0);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    bus.start = 1'b1;
    bus.a     = 8'h09;
    bus.b     = 8'h04;
    tick();
    wait_done(20, cyc);
    check("held first_latency", cyc, 8);
    check("held diff0", 32'(bus.diff), 32'h05);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("held done_low%0d", k), 32'(bus.done), 32'd0);
      wait_done(20, cyc);
      total = cyc + 1;
      check($sformatf("held period%0d", k), total, 10);
      check($sformatf("held diff%0d", k + 1), 32'(bus.diff), 32'h05);
    end
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("held drained", 32'(bus.busy), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    do_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0);
    check("80-01 ovf", 32'(bus.ovf), 32'd1);
    do_op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1);
    check("7F-FF ovf", 32'(bus.ovf), 32'd1);
    do_op("05-03b", 8'h05, 8'h03, 8'h02, 1'b0);
    check("05-03 ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset ovf", 32'(bus.ovf), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
